// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the front-panel digit-entry stage.
//   kp_state_t       : debounce FSM states
//   DIGIT_MAX        : entry register depth (m:ss -> 3 digits)
//   TENS_MAX         : largest legal seconds-tens value
//   kp_is_onehot()   : true when exactly one keypad line is set
//   kp_onehot_to_bcd(): one-hot key code -> BCD digit
// -----------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } kp_state_t;

   localparam int unsigned DIGIT_MAX = 3;
   localparam int unsigned TENS_MAX  = 5;

   function automatic logic kp_is_onehot(input logic [9:0] oh);
      // x & (x-1) clears the lowest set bit; zero afterwards means one bit set
      return (oh != '0) && ((oh & (oh - 10'd1)) == '0);
   endfunction

   function automatic logic [3:0] kp_onehot_to_bcd(input logic [9:0] oh);
      logic [3:0] bcd;
      bcd = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (oh[i]) bcd = 4'(i);
      end
      return bcd;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Debounces the ten raw keypad lines. A key is accepted once the same single
// key has been sampled DB_CYCLES times in a row; it must then be released for
// DB_CYCLES samples before another key can be accepted.
// Ports:
//   i_clk     : clock
//   i_rst_n   : asynchronous active-low reset
//   i_keys    : raw keypad lines, active high, bit n = digit n
//   i_en      : countdown running; forces HELD (entry locked out)
//   o_accept  : one-cycle accept, valid in the cycle before the accepting edge
//   o_code    : BCD code of the accepted key (qualified by o_accept)
// Parameters:
//   DB_CYCLES : samples required for press and for release, 1..15
// -----------------------------------------------------------------------------
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [9:0] i_keys,
   input  logic       i_en,
   output logic       o_accept,
   output logic [3:0] o_code
);

   localparam logic [3:0] LP_DB = 4'(DB_CYCLES);

   kp_state_t  r_state;
   kp_state_t  w_state_nxt;
   logic [3:0] r_count;
   logic [3:0] w_count_nxt;
   logic [9:0] r_key_oh;
   logic [9:0] w_key_oh_nxt;
   logic       w_valid;
   logic       w_none;
   logic       w_accept;

   assign w_valid = kp_is_onehot(i_keys);
   assign w_none  = (i_keys == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_key_oh <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_key_oh <= w_key_oh_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_key_oh_nxt = r_key_oh;
      w_accept     = 1'b0;
      if (i_en) begin
         // Parking in HELD means a key held across the end of the countdown
         // has to be released before it can count as a new press.
         w_state_nxt = HELD;
         w_count_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  w_key_oh_nxt = i_keys;
                  w_count_nxt  = 4'd1;
                  if (LP_DB == 4'd1) begin
                     w_accept    = 1'b1;
                     w_state_nxt = HELD;
                  end else begin
                     w_state_nxt = PRESS_WAIT;
                  end
               end
            end
            PRESS_WAIT: begin
               if (i_keys == r_key_oh) begin
                  w_count_nxt = r_count + 4'd1;
                  if (r_count + 4'd1 == LP_DB) begin
                     w_accept    = 1'b1;
                     w_state_nxt = HELD;
                  end
               end else begin
                  w_count_nxt = '0;
                  w_state_nxt = IDLE;
               end
            end
            HELD: begin
               if (w_none) begin
                  w_count_nxt = 4'd1;
                  w_state_nxt = (LP_DB == 4'd1) ? IDLE : RELEASE_WAIT;
               end
            end
            RELEASE_WAIT: begin
               if (w_none) begin
                  w_count_nxt = r_count + 4'd1;
                  if (r_count + 4'd1 == LP_DB) begin
                     w_count_nxt = '0;
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_count_nxt = '0;
                  w_state_nxt = HELD;
               end
            end
            default: begin
               w_count_nxt = '0;
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // On the accepting sample the live keys equal the latched code (or are the
   // code being latched when DB_CYCLES is 1), so encode the live sample.
   assign o_accept = w_accept;
   assign o_code   = kp_onehot_to_bcd(i_keys);

endmodule

// File: rtl/keypad_entry.sv
// -----------------------------------------------------------------------------
// keypad_entry
// Front-panel digit-entry stage of the microwave timer. Debounced digits are
// shifted into a three-digit m:ss register; each accepted digit pulses loadn
// so the timer counters load the displayed value. Entry is locked out and the
// register cleared while the countdown runs (en high).
// Ports:
//   clock  : system clock, rising edge
//   clearn : asynchronous active-low reset / front-panel clear
//   keys   : raw keypad lines, active high, bit n = digit n
//   en     : countdown running
//   ones   : seconds-ones BCD digit
//   tens   : seconds-tens BCD digit
//   mins   : minutes BCD digit
//   loadn  : active-low one-cycle load strobe to the timer counters
//   err    : one-cycle pulse on a rejected key
//   digits : number of digits entered (0..3)
// Parameters:
//   DB_CYCLES : debounce sample count, 1..15
// Build option:
//   KEYPAD_TENS_CHECK_EN : reject a digit that would shift a value >5 into tens
// -----------------------------------------------------------------------------
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic [9:0] keys,
   input  logic       en,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] mins,
   output logic       loadn,
   output logic       err,
   output logic [1:0] digits
);

   logic       w_accept;
   logic [3:0] w_code;
   logic       w_full;
   logic       w_tens_bad;

   logic [3:0] r_ones;
   logic [3:0] r_tens;
   logic [3:0] r_mins;
   logic       r_loadn;
   logic       r_err;
   logic [1:0] r_digits;

   keypad_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .i_clk    (clock),
      .i_rst_n  (clearn),
      .i_keys   (keys),
      .i_en     (en),
      .o_accept (w_accept),
      .o_code   (w_code)
   );

   assign w_full = (r_digits == 2'(DIGIT_MAX));

`ifdef KEYPAD_TENS_CHECK_EN
   assign w_tens_bad = (r_ones > 4'(TENS_MAX));
`else
   assign w_tens_bad = 1'b0;
`endif

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         r_ones   <= '0;
         r_tens   <= '0;
         r_mins   <= '0;
         r_loadn  <= 1'b1;
         r_err    <= 1'b0;
         r_digits <= '0;
      end else begin
         r_loadn <= 1'b1;
         r_err   <= 1'b0;
         if (en) begin
            r_ones   <= '0;
            r_tens   <= '0;
            r_mins   <= '0;
            r_digits <= '0;
         end else if (w_accept) begin
            if (w_full || w_tens_bad) begin
               r_err <= 1'b1;
            end else begin
               r_mins   <= r_tens;
               r_tens   <= r_ones;
               r_ones   <= w_code;
               r_digits <= r_digits + 2'd1;
               r_loadn  <= 1'b0;
            end
         end
      end
   end

   assign ones   = r_ones;
   assign tens   = r_tens;
   assign mins   = r_mins;
   assign loadn  = r_loadn;
   assign err    = r_err;
   assign digits = r_digits;

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;

   localparam int DB = 4;

   logic       clock;
   logic       clearn;
   logic [9:0] keys;
   logic       en;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [3:0] mins;
   logic       loadn;
   logic       err;
   logic [1:0] digits;

   int n_checks = 0;
   int n_fail   = 0;
   int loadn_tot = 0;
   int err_tot   = 0;

   keypad_entry #(
      .DB_CYCLES (DB)
   ) dut (
      .clock  (clock),
      .clearn (clearn),
      .keys   (keys),
      .en     (en),
      .ones   (ones),
      .tens   (tens),
      .mins   (mins),
      .loadn  (loadn),
      .err    (err),
      .digits (digits)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Strobes last one cycle, so counting at the falling edge sees each once.
   always @(negedge clock) begin
      if (clearn === 1'b1) begin
         if (loadn === 1'b0) loadn_tot++;
         if (err === 1'b1) err_tot++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running, need finished");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic press(input int d, input int n);
      keys = 10'd1 << d;
      tick(n);
      keys = '0;
   endtask

   task automatic do_clear();
      clearn = 1'b0;
      keys   = '0;
      en     = 1'b0;
      tick(2);
      clearn = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      clearn = 1'b0;
      keys   = '0;
      en     = 1'b0;
      tick(2);
      n_checks++;
      if ({mins, tens, ones} !== 12'h000 || digits !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_regs: got %h%h%h d=%0d, need 000 d=0", mins, tens, ones, digits);
      end
      n_checks++;
      if (loadn !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_strobes: got loadn=%b err=%b, need loadn=1 err=0", loadn, err);
      end
      clearn = 1'b1;
      tick(1);
   endtask

   task automatic test_single();
      int l0, e0;
      do_clear();
      l0 = loadn_tot;
      e0 = err_tot;
      keys = 10'd1 << 7;
      for (int i = 0; i < DB; i++) begin
         tick(1);
         n_checks++;
         if (i < DB - 1 && loadn !== 1'b1) begin
            n_fail++;
            $display("FAIL single_early: edge %0d got loadn=%b, need 1", i, loadn);
         end else if (i == DB - 1 && (loadn !== 1'b0 || ones !== 4'd7)) begin
            n_fail++;
            $display("FAIL single_accept_edge: got loadn=%b ones=%0d, need loadn=0 ones=7", loadn, ones);
         end
      end
      keys = '0;
      tick(1);
      n_checks++;
      if (loadn !== 1'b1) begin
         n_fail++;
         $display("FAIL single_strobe_width: got loadn=%b, need 1", loadn);
      end
      tick(DB + 2);
      n_checks++;
      if (ones !== 4'd7 || digits !== 2'd1 || loadn_tot - l0 != 1 || err_tot - e0 != 0) begin
         n_fail++;
         $display("FAIL single_result: got ones=%0d d=%0d loads=%0d errs=%0d, need 7 1 1 0",
                  ones, digits, loadn_tot - l0, err_tot - e0);
      end
   endtask

   task automatic test_sequence();
      int l0, e0;
      do_clear();
      l0 = loadn_tot;
      press(1, DB); tick(DB + 1);
      press(3, DB); tick(DB + 1);
      press(0, DB); tick(DB + 1);
      n_checks++;
      if (mins !== 4'd1 || tens !== 4'd3 || ones !== 4'd0 || digits !== 2'd3 || loadn_tot - l0 != 3) begin
         n_fail++;
         $display("FAIL seq_130: got %0d:%0d%0d d=%0d loads=%0d, need 1:30 d=3 loads=3",
                  mins, tens, ones, digits, loadn_tot - l0);
      end
      l0 = loadn_tot;
      e0 = err_tot;
      press(5, DB); tick(DB + 1);
      n_checks++;
      if (err_tot - e0 != 1 || loadn_tot - l0 != 0) begin
         n_fail++;
         $display("FAIL seq_full_reject: got errs=%0d loads=%0d, need errs=1 loads=0",
                  err_tot - e0, loadn_tot - l0);
      end
      n_checks++;
      if (mins !== 4'd1 || tens !== 4'd3 || ones !== 4'd0 || digits !== 2'd3) begin
         n_fail++;
         $display("FAIL seq_full_unchanged: got %0d:%0d%0d d=%0d, need 1:30 d=3", mins, tens, ones, digits);
      end
   endtask

   task automatic test_bounce();
      int l0, e0;
      do_clear();
      l0 = loadn_tot;
      press(7, 2);
      tick(1);
      press(7, DB);
      tick(DB + 1);
      n_checks++;
      if (loadn_tot - l0 != 1 || ones !== 4'd7 || digits !== 2'd1) begin
         n_fail++;
         $display("FAIL bounce_one_accept: got loads=%0d ones=%0d d=%0d, need 1 7 1",
                  loadn_tot - l0, ones, digits);
      end
      l0 = loadn_tot;
      e0 = err_tot;
      keys = 10'b00_0000_1100;
      tick(10);
      keys = '0;
      tick(DB + 1);
      n_checks++;
      if (loadn_tot - l0 != 0 || err_tot - e0 != 0 || digits !== 2'd1) begin
         n_fail++;
         $display("FAIL bounce_multi_key: got loads=%0d errs=%0d d=%0d, need 0 0 1",
                  loadn_tot - l0, err_tot - e0, digits);
      end
   endtask

   task automatic test_tens();
      int e0;
      do_clear();
      e0 = err_tot;
      press(9, DB); tick(DB + 1);
      press(1, DB); tick(DB + 1);
`ifdef KEYPAD_TENS_CHECK_EN
      n_checks++;
      if (err_tot - e0 != 1 || ones !== 4'd9 || tens !== 4'd0 || digits !== 2'd1) begin
         n_fail++;
         $display("FAIL tens_check: got errs=%0d tens=%0d ones=%0d d=%0d, need 1 0 9 1",
                  err_tot - e0, tens, ones, digits);
      end
`else
      n_checks++;
      if (err_tot - e0 != 0 || ones !== 4'd1 || tens !== 4'd9 || digits !== 2'd2) begin
         n_fail++;
         $display("FAIL tens_nocheck: got errs=%0d tens=%0d ones=%0d d=%0d, need 0 9 1 2",
                  err_tot - e0, tens, ones, digits);
      end
`endif
   endtask

   task automatic test_en();
      int l0, e0;
      do_clear();
      press(8, DB); tick(DB + 1);
      l0 = loadn_tot;
      e0 = err_tot;
      en   = 1'b1;
      keys = 10'd1 << 4;
      tick(DB + 2);
      n_checks++;
      if ({mins, tens, ones} !== 12'h000 || digits !== 2'd0 || loadn_tot - l0 != 0 || err_tot - e0 != 0) begin
         n_fail++;
         $display("FAIL en_lockout: got %h%h%h d=%0d loads=%0d errs=%0d, need 000 0 0 0",
                  mins, tens, ones, digits, loadn_tot - l0, err_tot - e0);
      end
      en = 1'b0;
      tick(2 * DB + 2);
      n_checks++;
      if (loadn_tot - l0 != 0 || digits !== 2'd0) begin
         n_fail++;
         $display("FAIL en_held_key: got loads=%0d d=%0d, need 0 0", loadn_tot - l0, digits);
      end
      keys = '0;
      tick(DB + 1);
      press(4, DB); tick(DB + 1);
      n_checks++;
      if (ones !== 4'd4 || digits !== 2'd1 || loadn_tot - l0 != 1) begin
         n_fail++;
         $display("FAIL en_repress: got ones=%0d d=%0d loads=%0d, need 4 1 1", ones, digits, loadn_tot - l0);
      end
   endtask

   task automatic test_back_to_back();
      do_clear();
      press(2, DB); tick(DB);
      press(6, DB); tick(DB);
      press(3, DB); tick(DB);
      n_checks++;
      if (mins !== 4'd2 || tens !== 4'd6 || ones !== 4'd3 || digits !== 2'd3) begin
         n_fail++;
         $display("FAIL b2b_min_spacing: got %0d:%0d%0d d=%0d, need 2:63 d=3", mins, tens, ones, digits);
      end
   endtask

   task automatic test_clear_mid_strobe();
      int l0;
      do_clear();
      press(2, DB); tick(DB + 1);
      keys = 10'd1 << 5;
      tick(DB);
      n_checks++;
      if (loadn !== 1'b0 || ones !== 4'd5) begin
         n_fail++;
         $display("FAIL clr_setup: got loadn=%b ones=%0d, need 0 5", loadn, ones);
      end
      #2;
      clearn = 1'b0;
      #1;
      n_checks++;
      if (loadn !== 1'b1 || {mins, tens, ones} !== 12'h000 || digits !== 2'd0) begin
         n_fail++;
         $display("FAIL clr_async: got loadn=%b %h%h%h d=%0d, need 1 000 0", loadn, mins, tens, ones, digits);
      end
      // Key still held after clear: an IDLE FSM accepts it without a release.
      tick(1);
      clearn = 1'b1;
      l0 = loadn_tot;
      tick(DB);
      n_checks++;
      if (loadn !== 1'b0 || ones !== 4'd5 || digits !== 2'd1) begin
         n_fail++;
         $display("FAIL clr_fsm_idle: got loadn=%b ones=%0d d=%0d, need 0 5 1", loadn, ones, digits);
      end
      keys = '0;
      tick(DB + 1);
      n_checks++;
      if (loadn_tot - l0 != 1) begin
         n_fail++;
         $display("FAIL clr_reaccept_count: got loads=%0d, need 1", loadn_tot - l0);
      end
   endtask

   initial begin
      clearn = 1'b0;
      keys   = '0;
      en     = 1'b0;
      test_reset();
      test_single();
      test_sequence();
      test_bounce();
      test_tens();
      test_en();
      test_back_to_back();
      test_clear_mid_strobe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
